// File: rtl/uart_cmd_dispatcher_pkg.sv
// Shared definitions for the UART command dispatcher.
//   - FSM state encoding
//   - opcode values carried in the first (opcode) byte of a frame
//   - QUERY response header nibble and a helper that builds the status byte
package uart_cmd_dispatcher_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_CH = 2'd1,
        EXEC    = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] OP_SET_ON  = 4'h1;
    localparam logic [3:0] OP_SET_OFF = 4'h2;
    localparam logic [3:0] OP_TOGGLE  = 4'h3;
    localparam logic [3:0] OP_QUERY   = 4'h4;
    localparam logic [3:0] OP_ALL_OFF = 4'h5;

    localparam logic [3:0] QUERY_HDR  = 4'hA;

    // Status byte returned by QUERY: header nibble, then the channel bit in the LSB.
    function automatic logic [7:0] query_resp(input logic ch_on);
        return {QUERY_HDR, 3'b000, ch_on};
    endfunction

endpackage

// File: rtl/uart_cmd_dispatcher_if.sv
// Byte-level link between uart_rx/uart_tx and the command dispatcher.
//   data_received / rx_done / parity_error : receive side, from uart_rx
//   tx_busy                                : transmitter busy, from uart_tx
//   data_to_tx / start_tx                  : transmit request, to uart_tx
// master = UART side (drives received bytes), slave = dispatcher.
interface uart_cmd_dispatcher_if;
    logic [7:0] data_received;
    logic       rx_done;
    logic       parity_error;
    logic       tx_busy;
    logic [7:0] data_to_tx;
    logic       start_tx;

    modport master (
        output data_received, rx_done, parity_error, tx_busy,
        input  data_to_tx, start_tx
    );

    modport slave (
        input  data_received, rx_done, parity_error, tx_busy,
        output data_to_tx, start_tx
    );
endinterface

// File: rtl/uart_cmd_dispatcher_hamming.sv
// Combinational Hamming(7,4) checker/decoder.
//   hamming_in_i[6:0]  : codeword, bit k-1 holds Hamming position k
//                        (positions 1,2,4 parity; 3,5,6,7 data d0..d3)
//   data_out_o[3:0]    : extracted data nibble {d3,d2,d1,d0}
//   error_detected_o   : non-zero syndrome
// No correction is applied: any flagged byte is rejected by the dispatcher.
module hamming_7_4_decoder (
    input  logic [6:0] hamming_in_i,
    output logic [3:0] data_out_o,
    output logic       error_detected_o
);
    logic [2:0] syndrome;

    assign syndrome[0] = ^{hamming_in_i[0], hamming_in_i[2], hamming_in_i[4], hamming_in_i[6]};
    assign syndrome[1] = ^{hamming_in_i[1], hamming_in_i[2], hamming_in_i[5], hamming_in_i[6]};
    assign syndrome[2] = ^{hamming_in_i[3], hamming_in_i[4], hamming_in_i[5], hamming_in_i[6]};

    assign data_out_o       = {hamming_in_i[6], hamming_in_i[5], hamming_in_i[4], hamming_in_i[2]};
    assign error_detected_o = |syndrome;
endmodule

// File: rtl/uart_cmd_dispatcher.sv
// Command layer between uart_rx/uart_tx and N_CH on/off channels.
// A frame is two Hamming(7,4)-protected bytes: opcode, then channel index.
// Every frame is answered with ACK, NACK or a QUERY status byte; an opcode
// byte with no follow-up inside TIMEOUT_CYC cycles is dropped silently.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : receive bytes in, response byte + start pulse out
//   ch_state_o   : channel states, 1 = ON
//   err_cnt_o    : saturating count of rejected / dropped frames and bytes
module uart_cmd_dispatcher
    import uart_cmd_dispatcher_pkg::*;
#(
    parameter int         N_CH        = 3,
    parameter int         TIMEOUT_CYC = 4800,
    parameter int         ERR_W       = 8,
    parameter logic [7:0] ACK_BYTE    = 8'h3C,
    parameter logic [7:0] NACK_BYTE   = 8'hC3
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_cmd_dispatcher_if.slave   bus,
    output logic [N_CH-1:0]        ch_state_o,
    output logic [ERR_W-1:0]       err_cnt_o
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t            state_q;
    logic [3:0]        opcode_q;
    logic [3:0]        idx_q;
    logic [TW-1:0]     timer_q;
    logic [N_CH-1:0]   ch_state_q;
    logic [7:0]        data_to_tx_q;
    logic              start_tx_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [ERR_W-1:0]  err_cnt_d;

    logic [3:0]        dec_data;
    logic              dec_err;
    logic              byte_bad;
    logic              timeout_hit;
    logic [N_CH-1:0]   ch_mask;
    logic              idx_ok;
    logic              exec_nack;
    logic [1:0]        err_inc;
    logic [ERR_W:0]    err_sum;

    hamming_7_4_decoder u_dec (
        .hamming_in_i     (bus.data_received[6:0]),
        .data_out_o       (dec_data),
        .error_detected_o (dec_err)
    );

    assign byte_bad    = bus.parity_error | bus.data_received[7] | dec_err;
    assign timeout_hit = (timer_q == TW'(TIMEOUT_CYC - 1));

    // One-hot channel select; an out-of-range index yields an all-zero mask.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_mask
        assign ch_mask[gi] = (idx_q == 4'(gi));
    end
    assign idx_ok = |ch_mask;

    always_comb begin
        exec_nack = 1'b1;
        case (opcode_q)
            OP_SET_ON, OP_SET_OFF, OP_TOGGLE, OP_QUERY: exec_nack = !idx_ok;
            OP_ALL_OFF:                                 exec_nack = 1'b0;
            default:                                    exec_nack = 1'b1;
        endcase
    end

    // An EXEC-cycle NACK and a dropped byte can coincide, so up to two
    // increments are summed before saturating.
    always_comb begin
        err_inc = 2'd0;
        case (state_q)
            IDLE:    err_inc = {1'b0, bus.rx_done & byte_bad};
            WAIT_CH: err_inc = {1'b0, bus.rx_done ? byte_bad : timeout_hit};
            EXEC:    err_inc = 2'({1'b0, exec_nack} + {1'b0, bus.rx_done});
            RESP:    err_inc = {1'b0, bus.rx_done};
            default: err_inc = 2'd0;
        endcase
        err_sum   = {1'b0, err_cnt_q} + (ERR_W + 1)'(err_inc);
        err_cnt_d = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            opcode_q     <= 4'h0;
            idx_q        <= 4'h0;
            timer_q      <= '0;
            ch_state_q   <= '0;
            data_to_tx_q <= 8'h00;
            start_tx_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            start_tx_q <= 1'b0;
            err_cnt_q  <= err_cnt_d;
            case (state_q)
                IDLE: begin
                    if (bus.rx_done) begin
                        if (byte_bad) begin
                            data_to_tx_q <= NACK_BYTE;
                            state_q      <= RESP;
                        end else begin
                            opcode_q <= dec_data;
                            timer_q  <= '0;
                            state_q  <= WAIT_CH;
                        end
                    end
                end
                WAIT_CH: begin
                    timer_q <= timer_q + 1'b1;
                    // A byte arriving on the timeout cycle takes priority.
                    if (bus.rx_done) begin
                        if (byte_bad) begin
                            data_to_tx_q <= NACK_BYTE;
                            state_q      <= RESP;
                        end else begin
                            idx_q   <= dec_data;
                            state_q <= EXEC;
                        end
                    end else if (timeout_hit) begin
                        state_q <= IDLE;
                    end
                end
                EXEC: begin
                    data_to_tx_q <= exec_nack ? NACK_BYTE : ACK_BYTE;
                    if (!exec_nack) begin
                        case (opcode_q)
                            OP_SET_ON:  ch_state_q <= ch_state_q | ch_mask;
                            OP_SET_OFF: ch_state_q <= ch_state_q & ~ch_mask;
                            OP_TOGGLE:  ch_state_q <= ch_state_q ^ ch_mask;
                            OP_QUERY:   data_to_tx_q <= query_resp(|(ch_state_q & ch_mask));
                            OP_ALL_OFF: ch_state_q <= '0;
                            default:    ch_state_q <= ch_state_q;
                        endcase
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (!bus.tx_busy) begin
                        start_tx_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_to_tx = data_to_tx_q;
    assign bus.start_tx   = start_tx_q;
    assign ch_state_o     = ch_state_q;
    assign err_cnt_o      = err_cnt_q;
endmodule
